// File: rtl/nvdla_pdp_nan_preproc_if.sv
// Valid/ready beat bundle between PDP RDMA, the NaN pre-processor and PDP core.
// Master drives vld/pd, slave returns rdy.
interface nvdla_pdp_nan_preproc_if #(
  parameter int W = 78
);
  logic         vld;
  logic         rdy;
  logic [W-1:0] pd;

  modport master (output vld, output pd, input rdy);
  modport slave  (input vld, input pd, output rdy);
endinterface

// File: rtl/nvdla_pdp_nan_preproc.sv
// PDP input-side NaN pre-processor: op_en gating, one registered stage,
// fp16 NaN/Inf detect/flush, and ping-pong banked saturating counts.
module nvdla_pdp_nan_preproc #(
  parameter int DATA_W = 64,
  parameter int INFO_W = 14,
  parameter int CNT_W  = 32
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rst,
  nvdla_pdp_nan_preproc_if.slave  pdp_rdma2dp,
  nvdla_pdp_nan_preproc_if.master nan_preproc,
  input  logic                   reg2dp_op_en,
  input  logic                   reg2dp_flying_mode,
  input  logic [1:0]             reg2dp_input_data,
  input  logic                   reg2dp_nan_to_zero,
  input  logic                   dp2reg_done,
  output logic [CNT_W-1:0]       dp2reg_nan_input_num,
  output logic [CNT_W-1:0]       dp2reg_inf_input_num
);

  localparam int LANES = DATA_W / 16;
  localparam int W     = DATA_W + INFO_W;
  localparam int CW    = $clog2(LANES + 1);

  logic              waiting_q, waiting_d;
  logic              pvld_q, pvld_d;
  logic              op_en_d1_q;
  logic [W-1:0]      pd_q, pd_d;
  logic [CW-1:0]     bnan_q, bnan_d;
  logic [CW-1:0]     binf_q, binf_d;
  logic [CNT_W-1:0]  nan_cnt_q, nan_cnt_d;
  logic [CNT_W-1:0]  inf_cnt_q, inf_cnt_d;
  logic [CNT_W-1:0]  nan_bank_q [2];
  logic [CNT_W-1:0]  inf_bank_q [2];
  logic              cube_flag_q;
  logic              done_flag_q;
  logic [CNT_W-1:0]  nan_rpt_q;
  logic [CNT_W-1:0]  inf_rpt_q;

  logic [W-1:0]      in_pd;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] data_out;
  logic [CW-1:0]     cnt_nan;
  logic [CW-1:0]     cnt_inf;
  logic [15:0]       lane;
  logic              l_nan, l_inf;
  logic              fp16;
  logic              rdy, load, out_acc;
  logic              op_en_load, layer_end;
  logic              cube_end_q;
  logic [CNT_W-1:0]  nan_sum, inf_sum;

  function automatic logic [CNT_W-1:0] sat_add(
    input logic [CNT_W-1:0] a,
    input logic [CW-1:0]    b
  );
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W+1-CW){1'b0}}, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  assign in_pd   = pdp_rdma2dp.pd;
  assign in_data = in_pd[DATA_W-1:0];
  assign fp16    = (reg2dp_input_data == 2'd2);

  always_comb begin
    data_out = in_data;
    cnt_nan  = '0;
    cnt_inf  = '0;
    lane     = '0;
    l_nan    = 1'b0;
    l_inf    = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      lane  = in_data[16*i +: 16];
      l_nan = fp16 & (&lane[14:10]) & (|lane[9:0]);
      l_inf = fp16 & (&lane[14:10]) & ~(|lane[9:0]);
      if (l_nan & reg2dp_nan_to_zero)
        data_out[16*i +: 16] = 16'h0000;
      cnt_nan = cnt_nan + CW'(l_nan);
      cnt_inf = cnt_inf + CW'(l_inf);
    end
  end

  assign rdy        = (~pvld_q | nan_preproc.rdy) & ~waiting_q;
  assign load       = pdp_rdma2dp.vld & rdy;
  assign out_acc    = pvld_q & nan_preproc.rdy;
  assign op_en_load = reg2dp_op_en & ~op_en_d1_q;
  assign layer_end  = load & in_pd[W-1] & in_pd[DATA_W+9];
  assign cube_end_q = pd_q[W-1];

  assign pdp_rdma2dp.rdy = rdy;
  assign nan_preproc.vld = pvld_q;
  assign nan_preproc.pd  = pd_q;

  assign dp2reg_nan_input_num = nan_rpt_q;
  assign dp2reg_inf_input_num = inf_rpt_q;

  always_comb begin
    waiting_d = waiting_q;
    unique case (1'b1)
      layer_end & reg2dp_flying_mode: waiting_d = 1'b1;
      op_en_load & ~(layer_end & reg2dp_flying_mode):
        waiting_d = ~reg2dp_flying_mode;
      default: waiting_d = waiting_q;
    endcase
  end

  always_comb begin
    pvld_d = pvld_q;
    pd_d   = pd_q;
    bnan_d = bnan_q;
    binf_d = binf_q;
    if (load) begin
      pvld_d = 1'b1;
      pd_d   = {in_pd[W-1:DATA_W], data_out};
      bnan_d = cnt_nan;
      binf_d = cnt_inf;
    end else if (out_acc) begin
      pvld_d = 1'b0;
    end
  end

  assign nan_sum = sat_add(nan_cnt_q, bnan_q);
  assign inf_sum = sat_add(inf_cnt_q, binf_q);

  // The cube-end beat's own lanes land in the bank, not the running count.
  always_comb begin
    nan_cnt_d = nan_cnt_q;
    inf_cnt_d = inf_cnt_q;
    if (out_acc) begin
      nan_cnt_d = cube_end_q ? '0 : nan_sum;
      inf_cnt_d = cube_end_q ? '0 : inf_sum;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      waiting_q     <= 1'b1;
      pvld_q        <= 1'b0;
      pd_q          <= '0;
      bnan_q        <= '0;
      binf_q        <= '0;
      op_en_d1_q    <= 1'b0;
      nan_cnt_q     <= '0;
      inf_cnt_q     <= '0;
      nan_bank_q[0] <= '0;
      nan_bank_q[1] <= '0;
      inf_bank_q[0] <= '0;
      inf_bank_q[1] <= '0;
      cube_flag_q   <= 1'b0;
      done_flag_q   <= 1'b0;
      nan_rpt_q     <= '0;
      inf_rpt_q     <= '0;
    end else begin
      waiting_q  <= waiting_d;
      pvld_q     <= pvld_d;
      pd_q       <= pd_d;
      bnan_q     <= bnan_d;
      binf_q     <= binf_d;
      op_en_d1_q <= reg2dp_op_en;
      nan_cnt_q  <= nan_cnt_d;
      inf_cnt_q  <= inf_cnt_d;
      if (out_acc & cube_end_q) begin
        nan_bank_q[cube_flag_q] <= nan_sum;
        inf_bank_q[cube_flag_q] <= inf_sum;
        cube_flag_q             <= ~cube_flag_q;
      end
      // Reads the bank value from before any same-cycle write.
      if (dp2reg_done) begin
        nan_rpt_q   <= nan_bank_q[done_flag_q];
        inf_rpt_q   <= inf_bank_q[done_flag_q];
        done_flag_q <= ~done_flag_q;
      end
    end
  end

endmodule

// File: tb/tb_nvdla_pdp_nan_preproc.sv
// Directed self-checking bench for nvdla_pdp_nan_preproc.
// A second instance with CNT_W=4 mirrors the stimulus for saturation.
module tb_nvdla_pdp_nan_preproc;

  localparam int DW = 64;
  localparam int IW = 14;
  localparam int W  = DW + IW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_en = 1'b0;
  logic        fly = 1'b0;
  logic [1:0]  idata = 2'd2;
  logic        ntz = 1'b0;
  logic        done = 1'b0;
  logic [31:0] nan_num, inf_num;
  logic [3:0]  nan4, inf4;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  nvdla_pdp_nan_preproc_if #(.W(W)) rin ();
  nvdla_pdp_nan_preproc_if #(.W(W)) rout ();
  nvdla_pdp_nan_preproc_if #(.W(W)) sin ();
  nvdla_pdp_nan_preproc_if #(.W(W)) sout ();

  assign sin.vld  = rin.vld;
  assign sin.pd   = rin.pd;
  assign sout.rdy = rout.rdy;

  nvdla_pdp_nan_preproc #(.DATA_W(DW), .INFO_W(IW), .CNT_W(32)) dut (
    .nvdla_core_clk       (clk),
    .nvdla_core_rst       (rst),
    .pdp_rdma2dp          (rin),
    .nan_preproc          (rout),
    .reg2dp_op_en         (op_en),
    .reg2dp_flying_mode   (fly),
    .reg2dp_input_data    (idata),
    .reg2dp_nan_to_zero   (ntz),
    .dp2reg_done          (done),
    .dp2reg_nan_input_num (nan_num),
    .dp2reg_inf_input_num (inf_num)
  );

  nvdla_pdp_nan_preproc #(.DATA_W(DW), .INFO_W(IW), .CNT_W(4)) sat (
    .nvdla_core_clk       (clk),
    .nvdla_core_rst       (rst),
    .pdp_rdma2dp          (sin),
    .nan_preproc          (sout),
    .reg2dp_op_en         (op_en),
    .reg2dp_flying_mode   (fly),
    .reg2dp_input_data    (idata),
    .reg2dp_nan_to_zero   (ntz),
    .dp2reg_done          (done),
    .dp2reg_nan_input_num (nan4),
    .dp2reg_inf_input_num (inf4)
  );

  // Drive one beat; returns at the negedge right after it is accepted.
  task automatic beat(input logic [IW-1:0] info, input logic [DW-1:0] data);
    int n;
    rin.vld = 1'b1;
    rin.pd  = {info, data};
    n = 0;
    while (!rin.rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rin.rdy !== 1'b1) begin
      fails++;
      $display("FAIL beat_timeout: ready=%b required 1", rin.rdy);
    end
    @(negedge clk);
    rin.vld = 1'b0;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rin.rdy !== 1'b0) begin
      fails++; $display("FAIL reset_ready: got %b required 0", rin.rdy);
    end
    checks++;
    if (rout.vld !== 1'b0) begin
      fails++; $display("FAIL reset_pvld: got %b required 0", rout.vld);
    end
    checks++;
    if (rout.pd !== '0) begin
      fails++; $display("FAIL reset_pd: got %h required 0", rout.pd);
    end
    checks++;
    if (nan_num !== 32'd0 || inf_num !== 32'd0) begin
      fails++;
      $display("FAIL reset_counts: got %0d/%0d required 0/0", nan_num, inf_num);
    end
    @(negedge clk);
    checks++;
    if (rin.rdy !== 1'b0) begin
      fails++; $display("FAIL pre_op_en_ready: got %b required 0", rin.rdy);
    end
    fly   = 1'b1;
    op_en = 1'b1;
    @(negedge clk);
    checks++;
    if (rin.rdy !== 1'b1) begin
      fails++; $display("FAIL op_en_open: got %b required 1", rin.rdy);
    end
  endtask

  task automatic test_fp16();
    idata = 2'd2;
    ntz   = 1'b1;
    beat(14'h2000, 64'h7E00_7C00_3C00_FC01);
    checks++;
    if (rout.vld !== 1'b1) begin
      fails++; $display("FAIL fp16_pvld: got %b required 1", rout.vld);
    end
    checks++;
    if (rout.pd !== {14'h2000, 64'h0000_7C00_3C00_0000}) begin
      fails++;
      $display("FAIL fp16_pd: got %h required %h", rout.pd,
               {14'h2000, 64'h0000_7C00_3C00_0000});
    end
    @(negedge clk);
    checks++;
    if (rout.vld !== 1'b0) begin
      fails++; $display("FAIL fp16_drain: got %b required 0", rout.vld);
    end
    pulse_done();
    checks++;
    if (nan_num !== 32'd2 || inf_num !== 32'd1) begin
      fails++;
      $display("FAIL fp16_counts: got %0d/%0d required 2/1", nan_num, inf_num);
    end
  endtask

  task automatic test_back_to_back();
    int got;
    logic [W-1:0] held;
    logic have_hold;
    got = 0;
    have_hold = 1'b0;
    held = '0;
    ntz = 1'b0;
    fork
      begin
        for (int i = 0; i < 100; i++)
          beat(14'h0000, 64'h1234_0000_0000_0000 | 64'(i));
      end
      begin
        for (int k = 0; k < 600 && got < 100; k++) begin
          @(posedge clk);
          #2;
          rout.rdy = !(k >= 20 && k < 25);
          @(negedge clk);
          if (rout.vld && !rout.rdy) begin
            checks++;
            if (rin.rdy !== 1'b0) begin
              fails++; $display("FAIL stall_ready: got %b required 0", rin.rdy);
            end
            if (have_hold) begin
              checks++;
              if (rout.pd !== held) begin
                fails++;
                $display("FAIL stall_pd: got %h required %h", rout.pd, held);
              end
            end
            held = rout.pd;
            have_hold = 1'b1;
          end else begin
            have_hold = 1'b0;
          end
          if (rout.vld && rout.rdy) begin
            checks++;
            if (rout.pd !== {14'h0000, 64'h1234_0000_0000_0000 | 64'(got)}) begin
              fails++;
              $display("FAIL b2b_order: got %h required beat %0d", rout.pd, got);
            end
            got++;
          end
        end
      end
    join
    rout.rdy = 1'b1;
    checks++;
    if (got != 100) begin
      fails++; $display("FAIL b2b_count: got %0d required 100", got);
    end
    @(negedge clk);
  endtask

  task automatic test_op_en();
    beat(14'h2200, 64'h0);
    checks++;
    if (rin.rdy !== 1'b0) begin
      fails++; $display("FAIL layer_end_close: got %b required 0", rin.rdy);
    end
    checks++;
    if (rout.vld !== 1'b1) begin
      fails++; $display("FAIL layer_end_beat: got %b required 1", rout.vld);
    end
    @(negedge clk);
    checks++;
    if (rout.vld !== 1'b0 || rin.rdy !== 1'b0) begin
      fails++;
      $display("FAIL layer_end_drain: pvld=%b ready=%b required 0/0",
               rout.vld, rin.rdy);
    end
    op_en = 1'b0;
    @(negedge clk);
    fly   = 1'b0;
    op_en = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (rin.rdy !== 1'b0) begin
      fails++; $display("FAIL on_fly_blocked: got %b required 0", rin.rdy);
    end
    op_en = 1'b0;
    @(negedge clk);
    fly   = 1'b1;
    op_en = 1'b1;
    @(negedge clk);
    checks++;
    if (rin.rdy !== 1'b1) begin
      fails++; $display("FAIL op_en_reopen: got %b required 1", rin.rdy);
    end
  endtask

  task automatic test_reset_midlayer();
    rout.rdy = 1'b0;
    beat(14'h0000, 64'hDEAD_BEEF_0000_0001);
    checks++;
    if (rout.vld !== 1'b1) begin
      fails++; $display("FAIL inflight_pvld: got %b required 1", rout.vld);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (rout.vld !== 1'b0 || rout.pd !== '0 || rin.rdy !== 1'b0) begin
      fails++;
      $display("FAIL midlayer_reset: pvld=%b pd=%h ready=%b required 0/0/0",
               rout.vld, rout.pd, rin.rdy);
    end
    rout.rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (rin.rdy !== 1'b1 || rout.vld !== 1'b0) begin
      fails++;
      $display("FAIL after_reset: ready=%b pvld=%b required 1/0",
               rin.rdy, rout.vld);
    end
  endtask

  task automatic send_cubes();
    beat(14'h0000, 64'h7E00_7E00_0000_0000);
    beat(14'h2000, 64'h7E01_0000_0000_0000);
    beat(14'h0000, 64'h7E00_7E00_7E00_7E00);
    beat(14'h2000, 64'h7C00_0000_0000_7C01);
  endtask

  task automatic test_ping_pong();
    idata = 2'd2;
    ntz   = 1'b0;
    send_cubes();
    repeat (2) @(negedge clk);
    pulse_done();
    checks++;
    if (nan_num !== 32'd3 || inf_num !== 32'd0) begin
      fails++;
      $display("FAIL pp_first: got %0d/%0d required 3/0", nan_num, inf_num);
    end
    pulse_done();
    checks++;
    if (nan_num !== 32'd5 || inf_num !== 32'd1) begin
      fails++;
      $display("FAIL pp_second: got %0d/%0d required 5/1", nan_num, inf_num);
    end
  endtask

  task automatic test_done_coincident();
    do_reset();
    send_cubes();
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    checks++;
    if (nan_num !== 32'd3 || inf_num !== 32'd0) begin
      fails++;
      $display("FAIL coinc_report: got %0d/%0d required 3/0", nan_num, inf_num);
    end
    pulse_done();
    checks++;
    if (nan_num !== 32'd5 || inf_num !== 32'd1) begin
      fails++;
      $display("FAIL coinc_bank1: got %0d/%0d required 5/1", nan_num, inf_num);
    end
  endtask

  task automatic test_int8();
    idata = 2'd0;
    ntz   = 1'b1;
    beat(14'h2000, 64'h7E00_7E00_7C00_FC01);
    checks++;
    if (rout.pd !== {14'h2000, 64'h7E00_7E00_7C00_FC01}) begin
      fails++;
      $display("FAIL int8_pd: got %h required %h", rout.pd,
               {14'h2000, 64'h7E00_7E00_7C00_FC01});
    end
    @(negedge clk);
    pulse_done();
    checks++;
    if (nan_num !== 32'd0 || inf_num !== 32'd0) begin
      fails++;
      $display("FAIL int8_counts: got %0d/%0d required 0/0", nan_num, inf_num);
    end
  endtask

  task automatic test_saturation();
    idata = 2'd2;
    ntz   = 1'b0;
    for (int i = 0; i < 4; i++)
      beat(14'h0000, 64'h7E00_7E00_7E00_7E00);
    beat(14'h2000, 64'h7E00_7E00_7E00_7E00);
    @(negedge clk);
    pulse_done();
    checks++;
    if (nan_num !== 32'd20) begin
      fails++; $display("FAIL wide_count: got %0d required 20", nan_num);
    end
    checks++;
    if (nan4 !== 4'd15 || inf4 !== 4'd0) begin
      fails++;
      $display("FAIL sat_count: got %0d/%0d required 15/0", nan4, inf4);
    end
  endtask

  initial begin
    rin.vld  = 1'b0;
    rin.pd   = '0;
    rout.rdy = 1'b1;
    @(negedge clk);
    test_reset();
    test_fp16();
    test_back_to_back();
    test_op_en();
    test_reset_midlayer();
    test_ping_pong();
    test_done_coincident();
    test_int8();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
